// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin synchronisation, clock deglitch filter and
// 11-bit frame deserialiser producing scan codes with error strobes.
module ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       new_code,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [FLT_W-1:0] flt_cnt_q;
  logic             clk_f_q, clk_f_prev_q;
  logic             fall;

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [7:0]       scan_q, scan_d;
  logic             new_q, new_d, perr_q, perr_d, ferr_q, ferr_d;

  // Idle-high pins: synchronisers and filtered clock reset to 1 so that
  // leaving reset never looks like a falling edge.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      flt_cnt_q    <= '0;
      clk_f_q      <= 1'b1;
      clk_f_prev_q <= 1'b1;
    end else begin
      clk_s1_q     <= ps2_clk;
      clk_s2_q     <= clk_s1_q;
      dat_s1_q     <= ps2_data;
      dat_s2_q     <= dat_s1_q;
      clk_f_prev_q <= clk_f_q;
      if (clk_s2_q == clk_f_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FLT_MAX) begin
        flt_cnt_q <= '0;
        clk_f_q   <= clk_s2_q;
      end else begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end
    end
  end

  assign fall = clk_f_prev_q & ~clk_f_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
      scan_q    <= '0;
      new_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
      scan_q    <= scan_d;
      new_q     <= new_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  // NOTE: every next-state variable is defaulted first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = to_cnt_q;
    scan_d    = scan_q;
    new_d     = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    // A fall in the same cycle as an expiring count wins: the count clears.
    if (fall || state_q == IDLE) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_MAX) begin
      to_cnt_d = '0;
      state_d  = IDLE;
      ferr_d   = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            par_d     = 1'b0;
          end
        end
        DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          par_d     = par_q ^ dat_s2_q;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = par_q ^ dat_s2_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!dat_s2_q) begin
            ferr_d = 1'b1;
          end else if (!par_q) begin
            perr_d = 1'b1;
          end else begin
            new_d  = 1'b1;
            scan_d = shift_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign scan_code  = scan_q;
  assign new_code   = new_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Directed self-checking bench for ps2_rx: valid, back-to-back, parity/stop
// errors, timeout, clock glitches and mid-frame reset.
module tb_ps2_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       new_code, parity_err, frame_err, busy;

  ps2_rx #(.FILTER_LEN(4), .TIMEOUT_CYC(400)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .new_code   (new_code),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_new, n_par, n_frm, multi, frm_cyc, drop_cyc;
  logic [7:0] codes[$];
  logic busy_mid;
  logic prev_strobe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor sampled on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (!rst) begin
      if (new_code) begin n_new++; codes.push_back(scan_code); end
      if (parity_err) n_par++;
      if (frame_err) begin n_frm++; frm_cyc = cyc; end
      if (int'(new_code) + int'(parity_err) + int'(frame_err) > 1) multi++;
      if (prev_strobe && (new_code || parity_err || frame_err)) multi++;
    end
    prev_strobe = new_code | parity_err | frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_new = 0; n_par = 0; n_frm = 0;
    codes.delete();
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic pflip, input logic stop);
    return {stop, (~^d) ^ pflip, d, 1'b0};
  endfunction

  // Sends the first nfalls bits of a frame; rst_at selects the bit whose
  // preceding high phase carries a one-cycle reset pulse (-1 for none).
  task automatic send(input logic [10:0] b, input int nfalls, input bit glitch, input int rst_at);
    for (int i = 0; i < nfalls; i++) begin
      if (i == rst_at) begin
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_scan_code", 32'(scan_code), 32'h00);
        check("rst_new_code", 32'(new_code), 0);
        check("rst_parity_err", 32'(parity_err), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_busy", 32'(busy), 0);
        tick(14);
      end else if (glitch) begin
        tick(5); ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(12);
      end else begin
        tick(20);
      end
      ps2_data = b[i];
      tick(20);
      ps2_clk = 1'b0;
      drop_cyc = cyc;
      tick(40);
      if (i == 0) busy_mid = busy;
      ps2_clk = 1'b1;
    end
    tick(20);
    ps2_data = 1'b1;
    tick(20);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    multi = 0; frm_cyc = 0; drop_cyc = 0; busy_mid = 1'b0;
    clear_counts();
    tick(5);
    check("reset_scan_code", 32'(scan_code), 32'h00);
    check("reset_new_code", 32'(new_code), 0);
    check("reset_parity_err", 32'(parity_err), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    check("reset_busy", 32'(busy), 0);
    rst = 1'b0;
    tick(20);

    // 1. single valid frame
    clear_counts();
    send(mk(8'h1C, 1'b0, 1'b1), 11, 1'b0, -1);
    check("t1_new_count", n_new, 1);
    check("t1_code", (codes.size() > 0) ? 32'(codes[0]) : 32'hFFFF, 32'h1C);
    check("t1_parity_err", n_par, 0);
    check("t1_frame_err", n_frm, 0);
    check("t1_busy_mid", 32'(busy_mid), 1);
    check("t1_busy_end", 32'(busy), 0);

    // 2. back-to-back frames
    clear_counts();
    send(mk(8'hF0, 1'b0, 1'b1), 11, 1'b0, -1);
    send(mk(8'h1C, 1'b0, 1'b1), 11, 1'b0, -1);
    check("t2_new_count", n_new, 2);
    check("t2_code0", (codes.size() > 0) ? 32'(codes[0]) : 32'hFFFF, 32'hF0);
    check("t2_code1", (codes.size() > 1) ? 32'(codes[1]) : 32'hFFFF, 32'h1C);
    check("t2_errors", n_par + n_frm, 0);

    // 3. parity error, then bad stop bit
    clear_counts();
    send(mk(8'h1C, 1'b1, 1'b1), 11, 1'b0, -1);
    check("t3a_parity_err", n_par, 1);
    check("t3a_new_count", n_new, 0);
    check("t3a_frame_err", n_frm, 0);
    check("t3a_scan_held", 32'(scan_code), 32'h1C);
    clear_counts();
    send(mk(8'h1C, 1'b0, 1'b0), 11, 1'b0, -1);
    check("t3b_frame_err", n_frm, 1);
    check("t3b_parity_err", n_par, 0);
    check("t3b_new_count", n_new, 0);

    // 4. clock stops after the 5th data bit
    clear_counts();
    send(mk(8'h1C, 1'b0, 1'b1), 6, 1'b0, -1);
    for (int k = 0; k < 600 && n_frm == 0; k++) tick(1);
    tick(2);
    check("t4_frame_err", n_frm, 1);
    check("t4_timeout_delay_ok", 32'((frm_cyc - drop_cyc >= 403) && (frm_cyc - drop_cyc <= 409)), 1);
    check("t4_busy", 32'(busy), 0);
    check("t4_scan_held", 32'(scan_code), 32'h1C);
    clear_counts();
    send(mk(8'h75, 1'b0, 1'b1), 11, 1'b0, -1);
    check("t4_new_count", n_new, 1);
    check("t4_code", (codes.size() > 0) ? 32'(codes[0]) : 32'hFFFF, 32'h75);

    // 5. glitches while idle and inside a frame
    clear_counts();
    for (int g = 0; g < 3; g++) begin
      tick(5); ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(20);
    end
    check("t5_idle_busy", 32'(busy), 0);
    check("t5_idle_strobes", n_new + n_par + n_frm, 0);
    send(mk(8'h6B, 1'b0, 1'b1), 11, 1'b1, -1);
    check("t5_new_count", n_new, 1);
    check("t5_code", (codes.size() > 0) ? 32'(codes[0]) : 32'hFFFF, 32'h6B);
    check("t5_errors", n_par + n_frm, 0);

    // 6. reset after the 4th data bit; remaining bits are all ones
    clear_counts();
    send(mk(8'hF0, 1'b0, 1'b1), 11, 1'b0, 5);
    tick(500);
    check("t6_no_strobes", n_new + n_par + n_frm, 0);
    check("t6_busy", 32'(busy), 0);
    send(mk(8'h2D, 1'b0, 1'b1), 11, 1'b0, -1);
    check("t6_new_count", n_new, 1);
    check("t6_code", (codes.size() > 0) ? 32'(codes[0]) : 32'hFFFF, 32'h2D);

    check("strobe_exclusive", multi, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
PS/2 device-to-host receiver. It synchronises and deglitches the raw ps2_clk/ps2_data pins and deserialises each 11-bit frame (start, 8 data LSB-first, odd parity, stop). It then emits one scan_code byte with a single-cycle new_code strobe. It sits directly upstream of the scan-code decoder and drives that decoder's scan_code/new_code inputs; frames with errors are dropped and flagged.

Parameters:
FILTER_LEN, 8, consecutive clk cycles the synchronised ps2_clk must hold a new level before the filtered clock changes (min 2)
TIMEOUT_CYC, 50000, max clk cycles between filtered falling edges inside a frame before abort (1 ms at 50 MHz)

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
ps2_clk  input  1  raw PS/2 clock pin, asynchronous
ps2_data  input  1  raw PS/2 data pin, asynchronous
scan_code  output  8  last correctly received byte; held between frames
new_code  output  1  1-cycle strobe; scan_code valid in the same cycle
parity_err  output  1  1-cycle strobe; frame dropped on parity mismatch
frame_err  output  1  1-cycle strobe; frame dropped on bad stop bit or timeout
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Input conditioning: 2-FF synchroniser on each pin; synchroniser FFs reset to 1.
- Clock filter: clk_f resets to 1. clk_f takes the synchronised value only after that value has differed from clk_f for FILTER_LEN consecutive cycles. Any shorter pulse is ignored and its counter cleared.
- fall = clk_f transitions 1->0 (single-cycle, detected on the clk_f register). Data is sampled from the synchronised ps2_data on the fall cycle. No data filter.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions happen only on fall cycles, except timeout and reset.
  - IDLE: on fall with data=0 -> DATA, bit_cnt=0, parity accumulator=0. On fall with data=1 -> stay in IDLE, no error flagged.
  - DATA: on each fall, shift data into bit 7 of the shift register (LSB-first result) and XOR it into the accumulator. After the 8th bit (bit_cnt reaches 7) -> PARITY.
  - PARITY: on fall, capture the parity bit -> STOP.
  - STOP: on fall -> IDLE, with the following outcome:
    - Stop bit=0: frame_err=1. This takes priority over a parity error.
    - Else if the XOR of the 8 data bits and the parity bit is 0 (even count): parity_err=1.
    - Else: scan_code<=shift register, new_code=1.
- Output latency: strobes and scan_code update are registered. They are visible in the cycle after the stop-bit fall cycle, and exactly one strobe fires per completed frame.
- Timeout: the counter clears on every fall and while in IDLE. It increments in any other state. When it reaches TIMEOUT_CYC-1 outside IDLE: FSM -> IDLE, frame_err=1 for one cycle, scan_code unchanged.
- Simultaneous events: a fall and a timeout in the same cycle are resolved in favour of the fall (the counter clears).
- Strobe exclusivity: new_code, parity_err and frame_err are never high together and are never high in consecutive cycles for the same frame.
- Reset values: scan_code=8'h00, new_code=0, parity_err=0, frame_err=0, busy=0; FSM=IDLE, counters 0, clk_f=1.
- Reset mid-frame: the partial frame is discarded with no strobe. The next start bit after reset is received normally.
- Back-to-back frames: a start bit on the first fall after STOP is accepted; no idle gap is required.
- Width rules:
  - Filter counter: $clog2(FILTER_LEN+1) bits.
  - Timeout counter: $clog2(TIMEOUT_CYC) bits, saturating in effect, since it forces IDLE.

Test Plan:
(Bench uses FILTER_LEN=4, TIMEOUT_CYC=400 and a PS/2 half-period of 40 clk cycles. Data changes 20 cycles after each rising ps2_clk edge.)
1. Valid frame for 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) -> exactly one new_code pulse with scan_code=8'h1C; parity_err=frame_err=0; busy high from the start-bit fall until the stop-bit fall.
2. Back-to-back 0xF0 then 0x1C with no gap -> two new_code pulses with scan_code 8'hF0 then 8'h1C; no error strobes.
3. Frame 0x1C with parity bit flipped to 1 -> parity_err pulse once, no new_code, scan_code keeps its previous value. The same frame with stop=0 -> frame_err only.
4. Stop toggling ps2_clk after the 5th data bit -> frame_err pulse 400 cycles after the last fall, busy drops; a following valid 0x75 frame is received correctly.
5. 3-cycle low glitches on ps2_clk while idle and mid-frame -> no state change, no strobes; the surrounding frame 0x6B decodes correctly.
6. Assert rst for 1 cycle after the 4th data bit -> all outputs 0 and busy=0 the next cycle; the rest of the frame produces no strobe; the next valid frame 0x2D yields new_code with 8'h2D.
